hwpe_ctrl_arbiter: RTL and testbench
====================================

HWPE_CTRL_ARBITER -- requirements
Module: hwpe_ctrl_arbiter

Interface
REQ-001 SHALL have parameter NrPorts, default 8, number of requesting cores (2..16).
REQ-002 SHALL have parameter DataWidth, default 32, control data width; AddrWidth default 32; IdWidth default 8.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, owner-inactivity limit (>=2).
REQ-004 SHALL have one clock; reset is synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  sync active-high reset
REQ-005 SHALL have these requester-side ports:
- req_valid_i  in  NrPorts  per-core request valid
- req_addr_i  in  NrPorts x AddrWidth  byte address
- req_write_i  in  NrPorts  1 = write
- req_wdata_i  in  NrPorts x DataWidth  write data
- req_strb_i  in  NrPorts x DataWidth/8  byte strobes
- req_ready_o  out  NrPorts  per-core accept
- rsp_valid_o  out  NrPorts  per-core response valid
- rsp_data_o  out  DataWidth  response data, shared by all cores
- rsp_err_o  out  1  response error, qualified by rsp_valid_o
REQ-006 SHALL have these HWPE-side ports:
- m_valid_o  out  1  request to HWPE periph
- m_addr_o  out  AddrWidth  address
- m_write_o  out  1  write
- m_wdata_o  out  DataWidth  write data
- m_strb_o  out  DataWidth/8  strobes
- m_id_o  out  IdWidth  owner index, zero-extended
- m_ready_i  in  1  grant
- m_rsp_valid_i  in  1  response valid
- m_rsp_data_i  in  DataWidth  response data
- hwpe_evt_i  in  1  job-done pulse
- owner_o  out  clog2(NrPorts)  current owner index
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on timeout release

Function
REQ-007 SHALL implement FSM IDLE, OWNED, RUNNING.
REQ-008 IDLE: SHALL select one valid requester by round-robin, starting after the last owner. The selection SHALL take effect on the next clock edge: owner_q is set, the state moves to OWNED, and the request is not accepted in that cycle.
REQ-009 OWNED: SHALL forward only owner requests to m_*. All non-owner req_ready_o SHALL be 0.
REQ-010 Local register offset 0x04 (addr[7:0]), RELEASE: an owner write SHALL be accepted locally (not forwarded), give a response with data 0 on the next cycle, and move the state to IDLE.
REQ-011 Local register offset 0x00, TRIGGER: an owner write SHALL be forwarded to the HWPE. On handshake (m_valid_o && m_ready_i), the state SHALL move to RUNNING.
REQ-012 RUNNING: SHALL forward owner reads only. Owner writes SHALL be stalled (req_ready_o = 0).
REQ-013 RUNNING: hwpe_evt_i SHALL move the state to IDLE. In IDLE and OWNED, hwpe_evt_i SHALL be ignored.
REQ-014 SHALL allow at most one outstanding forwarded transaction, with m_valid_o gated by !pending_q. pending_q SHALL set on handshake and clear on m_rsp_valid_i.
REQ-015 m_rsp_valid_i SHALL be routed to rsp_valid_o[owner_q] in the same cycle, with rsp_data_o = m_rsp_data_i and rsp_err_o = 0.
REQ-016 The request path SHALL be combinational: req_ready_o[owner] = m_ready_i && !pending_q for forwarded accesses.
REQ-017 A write to offset 0x00 or 0x04 by a non-owner SHALL be impossible, because non-owners are stalled.
REQ-018 In OWNED only, an inactivity counter SHALL count cycles with no owner handshake and no pending response. It SHALL clear on any owner handshake or response.
REQ-019 When the counter reaches TimeoutCycles-1, the block SHALL pulse timeout_o and go to IDLE. A pending response SHALL still be delivered to the old owner before any new grant.
REQ-020 IDLE SHALL NOT issue a grant while pending_q = 1.
REQ-021 Simultaneous events:
- hwpe_evt_i in the same cycle as an owner read handshake in RUNNING: the handshake completes, the state goes to IDLE, and the response still routes to the old owner.
- RELEASE and timeout in the same cycle: release wins; timeout_o = 0.
REQ-022 The round-robin pointer SHALL wrap from NrPorts-1 to 0.

Reset
REQ-023 rst_i SHALL force on the next edge:
- state IDLE, owner_q 0, round-robin pointer NrPorts-1, pending_q 0, counter 0
- all req_ready_o, rsp_valid_o, m_valid_o, timeout_o = 0; busy_o = 0
REQ-024 Reset mid-transaction SHALL drop the pending response. A subsequent m_rsp_valid_i while pending_q = 0 SHALL be ignored.

Structure
REQ-025 The shared package hwpe_arb_pkg SHALL hold:
- the state enum arb_state_e
- local offsets TriggerOffset = 8'h00 and ReleaseOffset = 8'h04
REQ-026 The round-robin selector SHALL be one sub-module, hwpe_rr_select (request vector and pointer in; one-hot grant and index out).
REQ-027 SHALL be a single clock domain with no gated clocks inside.

Verification
REQ-028 Cores 2 and 5 request in IDLE after reset -> owner_o = 2 two cycles later; core 5 ready stays 0 until core 2 releases, then owner_o = 5.
REQ-029 Owner writes 0x00 with m_ready_i = 1 -> busy_o = 1 and state RUNNING; an owner write then stalls; hwpe_evt_i pulse -> IDLE next cycle.
REQ-030 Owner reads with m_rsp_valid_i 3 cycles later -> rsp_valid_o[owner] = 1 with data 0xDEADBEEF; no second m_valid_o during the gap.
REQ-031 TimeoutCycles = 16, owner idle -> timeout_o pulses at cycle 16 after grant; the next requester is granted.
REQ-032 rst_i asserted with pending_q = 1, then a late m_rsp_valid_i -> no rsp_valid_o; all outputs 0.
REQ-033 All 8 cores request continuously with immediate release -> grant order 0..7,0 (wrap-around).

Source files
------------

// File: rtl/hwpe_arb_pkg.sv
// Shared types and local register offsets for the HWPE control-port arbiter.
package hwpe_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWNED   = 2'd1,
    ARB_RUNNING = 2'd2
  } arb_state_e;

  localparam logic [7:0] TriggerOffset = 8'h00;
  localparam logic [7:0] ReleaseOffset = 8'h04;

endpackage

// File: rtl/hwpe_rr_select.sv
// Round-robin requester picker: first active request strictly after ptr_i,
// wrapping from NrPorts-1 back to 0. Purely combinational.
module hwpe_rr_select #(
  parameter  int unsigned NrPorts = 8,
  localparam int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic [NrPorts-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NrPorts-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  int unsigned cand;
  logic        found;

  // Scan offsets 1..NrPorts so the previous owner is the last candidate.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= NrPorts; off++) begin
      cand = 32'(ptr_i) + off;
      if (cand >= NrPorts) cand = cand - NrPorts;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IdxW-1:0]] = 1'b1;
        idx_o                 = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/hwpe_ctrl_arbiter.sv
// Arbitrates ownership of a single HWPE control port among NrPorts cores.
// A core owns the port from grant until it writes RELEASE, its triggered job
// finishes, or it stays inactive for TimeoutCycles cycles.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ARB_IDLE    | no owner; pick next requester once no response is pending
//   ARB_OWNED   | owner may access registers, trigger a job or release
//   ARB_RUNNING | job running; owner reads forwarded, writes stalled
module hwpe_ctrl_arbiter
  import hwpe_arb_pkg::*;
#(
  parameter  int unsigned NrPorts       = 8,
  parameter  int unsigned DataWidth     = 32,
  parameter  int unsigned AddrWidth     = 32,
  parameter  int unsigned IdWidth       = 8,
  parameter  int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxW          = (NrPorts > 1) ? $clog2(NrPorts) : 1,
  localparam int unsigned StrbW         = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrPorts-1:0]                  req_valid_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0]   req_addr_i,
  input  logic [NrPorts-1:0]                  req_write_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]   req_wdata_i,
  input  logic [NrPorts-1:0][StrbW-1:0]       req_strb_i,
  output logic [NrPorts-1:0]                  req_ready_o,
  output logic [NrPorts-1:0]                  rsp_valid_o,
  output logic [DataWidth-1:0]                rsp_data_o,
  output logic                                rsp_err_o,
  output logic                                m_valid_o,
  output logic [AddrWidth-1:0]                m_addr_o,
  output logic                                m_write_o,
  output logic [DataWidth-1:0]                m_wdata_o,
  output logic [StrbW-1:0]                    m_strb_o,
  output logic [IdWidth-1:0]                  m_id_o,
  input  logic                                m_ready_i,
  input  logic                                m_rsp_valid_i,
  input  logic [DataWidth-1:0]                m_rsp_data_i,
  input  logic                                hwpe_evt_i,
  output logic [IdxW-1:0]                     owner_o,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int unsigned     CntW        = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  pending_q, pending_d;
  logic                  rel_rsp_q, rel_rsp_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [NrPorts-1:0]    sel_gnt;
  logic [IdxW-1:0]       sel_idx;

  logic                  o_valid, o_write, o_is_rel, o_is_trig;
  logic [AddrWidth-1:0]  o_addr;
  logic                  fwd_en, loc_en, fwd_hs, loc_hs, rsp_hs;

  hwpe_rr_select #(
    .NrPorts (NrPorts)
  ) i_rr_select (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx)
  );

  assign o_valid   = req_valid_i[owner_q];
  assign o_addr    = req_addr_i[owner_q];
  assign o_write   = req_write_i[owner_q];
  assign o_is_rel  = o_write && (o_addr[7:0] == ReleaseOffset);
  assign o_is_trig = o_write && (o_addr[7:0] == TriggerOffset);

  assign owner_o   = owner_q;
  assign m_id_o    = IdWidth'(owner_q);
  assign busy_o    = (state_q != ARB_IDLE);
  assign rsp_err_o = 1'b0;

  // Owner request routing, response steering and next-state selection.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    pending_d   = pending_q;
    rel_rsp_d   = 1'b0;
    cnt_d       = cnt_q;
    fwd_en      = 1'b0;
    loc_en      = 1'b0;
    timeout_o   = 1'b0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    m_addr_o    = '0;
    m_write_o   = 1'b0;
    m_wdata_o   = '0;
    m_strb_o    = '0;

    case (state_q)
      ARB_OWNED: begin
        loc_en = o_is_rel;
        fwd_en = !o_is_rel;
      end
      ARB_RUNNING: fwd_en = !o_write;
      default: ;
    endcase

    m_valid_o = fwd_en && o_valid && !pending_q;
    fwd_hs    = m_valid_o && m_ready_i;
    loc_hs    = loc_en && o_valid && !pending_q;
    rsp_hs    = pending_q && m_rsp_valid_i;

    if (fwd_en || loc_en) req_ready_o[owner_q] = !pending_q && (loc_en || m_ready_i);

    if (m_valid_o) begin
      m_addr_o  = o_addr;
      m_write_o = o_write;
      m_wdata_o = req_wdata_i[owner_q];
      m_strb_o  = req_strb_i[owner_q];
    end

    // owner_q only changes on a grant, which waits for pending_q to clear,
    // so late responses still reach the core that issued them.
    if (rsp_hs) begin
      rsp_valid_o[owner_q] = 1'b1;
      rsp_data_o           = m_rsp_data_i;
    end else if (rel_rsp_q) begin
      rsp_valid_o[owner_q] = 1'b1;
    end

    if (fwd_hs)      pending_d = 1'b1;
    else if (rsp_hs) pending_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (!pending_q && (|sel_gnt)) begin
          owner_d  = sel_idx;
          rr_ptr_d = sel_idx;
          state_d  = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (loc_hs) begin
          state_d   = ARB_IDLE;
          rel_rsp_d = 1'b1;
          cnt_d     = '0;
        end else if (fwd_hs || rsp_hs) begin
          cnt_d = '0;
          if (fwd_hs && o_is_trig) state_d = ARB_RUNNING;
        end else if (!pending_q) begin
          if (cnt_q == TimeoutLast) begin
            timeout_o = 1'b1;
            state_d   = ARB_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      ARB_RUNNING: begin
        cnt_d = '0;
        if (hwpe_evt_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= IdxW'(NrPorts - 1);
      pending_q <= 1'b0;
      rel_rsp_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      rel_rsp_q <= rel_rsp_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_arbiter.sv
// Directed bench for hwpe_ctrl_arbiter. Stimulus pushes expected responses to
// a scoreboard queue; a negedge monitor pops and compares every response.
module tb_hwpe_ctrl_arbiter;

  localparam int NP = 8;

  logic             clk, rst_i;
  logic [7:0]       req_valid, req_write, req_ready, rsp_valid;
  logic [7:0][31:0] req_addr, req_wdata;
  logic [7:0][3:0]  req_strb;
  logic [31:0]      rsp_data, m_addr, m_wdata, m_rsp_data;
  logic             rsp_err, m_valid, m_write, m_ready, m_rsp_valid, hwpe_evt;
  logic [3:0]       m_strb;
  logic [7:0]       m_id;
  logic [2:0]       owner;
  logic             busy, timeout;

  hwpe_ctrl_arbiter #(
    .NrPorts(8), .DataWidth(32), .AddrWidth(32), .IdWidth(8), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_write_i(req_write),
    .req_wdata_i(req_wdata), .req_strb_i(req_strb), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .m_valid_o(m_valid), .m_addr_o(m_addr), .m_write_o(m_write),
    .m_wdata_o(m_wdata), .m_strb_o(m_strb), .m_id_o(m_id),
    .m_ready_i(m_ready), .m_rsp_valid_i(m_rsp_valid), .m_rsp_data_i(m_rsp_data),
    .hwpe_evt_i(hwpe_evt), .owner_o(owner), .busy_o(busy), .timeout_o(timeout)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic w, input logic [31:0] a);
    req_valid[p] = v;
    req_write[p] = w;
    req_addr[p]  = a;
    req_wdata[p] = 32'h100 + 32'(p);
    req_strb[p]  = 4'hF;
  endtask

  task automatic expect_rsp(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid !== 8'h00) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", {24'h0, rsp_valid}, 32'h0);
      end else begin
        exp_t e;
        logic [7:0] oh;
        e  = sb_q.pop_front();
        oh = 8'h00;
        oh[e.port[2:0]] = 1'b1;
        chk("rsp_port", {24'h0, rsp_valid}, {24'h0, oh});
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'h0, rsp_err}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit found;
    rst_i = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    m_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0; hwpe_evt = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    chk("rst_owner", {29'h0, owner}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {24'h0, req_ready}, 32'h0);
    chk("rst_mvalid", {31'h0, m_valid}, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);

    // Cores 2 and 5 request together; 2 wins first.
    tick();
    drive(2, 1'b1, 1'b0, 32'h10);
    drive(5, 1'b1, 1'b0, 32'h10);
    m_ready = 1'b1;
    #1 chk("idle_no_ready", {24'h0, req_ready}, 32'h0);
    tick();
    #1;
    chk("grant2_owner", {29'h0, owner}, 32'h2);
    chk("grant2_busy", {31'h0, busy}, 32'h1);
    chk("grant2_ready", {24'h0, req_ready}, 32'h04);
    chk("fwd_addr", m_addr, 32'h10);
    chk("fwd_id", {24'h0, m_id}, 32'h2);
    tick();
    drive(2, 1'b0, 1'b0, 32'h10);
    m_rsp_valid = 1'b1; m_rsp_data = 32'h12345678;
    expect_rsp(2, 32'h12345678);
    #1 chk("pending_no_mvalid", {31'h0, m_valid}, 32'h0);
    tick();
    m_rsp_valid = 1'b0;
    drive(2, 1'b1, 1'b1, 32'h04);
    expect_rsp(2, 32'h0);
    #1;
    chk("release_ready", {24'h0, req_ready}, 32'h04);
    chk("release_local", {31'h0, m_valid}, 32'h0);
    tick();
    drive(2, 1'b0, 1'b0, 32'h0);
    #1 chk("release_idle", {31'h0, busy}, 32'h0);
    tick();

    // Core 5 now owns: trigger, stalled write, read with delayed response.
    drive(5, 1'b1, 1'b1, 32'h00);
    #1;
    chk("grant5_owner", {29'h0, owner}, 32'h5);
    chk("trig_ready", {24'h0, req_ready}, 32'h20);
    chk("trig_mwrite", {31'h0, m_write}, 32'h1);
    tick();
    drive(5, 1'b1, 1'b1, 32'h10);
    m_rsp_valid = 1'b1; m_rsp_data = 32'h1;
    expect_rsp(5, 32'h1);
    #1 chk("running_busy", {31'h0, busy}, 32'h1);
    tick();
    m_rsp_valid = 1'b0;
    #1;
    chk("running_wr_stall", {24'h0, req_ready}, 32'h0);
    chk("running_wr_nofwd", {31'h0, m_valid}, 32'h0);
    tick();
    drive(5, 1'b1, 1'b0, 32'h20);
    #1 chk("running_rd_ready", {24'h0, req_ready}, 32'h20);
    tick();
    #1 chk("gap1_mvalid", {31'h0, m_valid}, 32'h0);
    tick();
    #1 chk("gap2_mvalid", {31'h0, m_valid}, 32'h0);
    tick();
    drive(5, 1'b0, 1'b0, 32'h0);
    m_rsp_valid = 1'b1; m_rsp_data = 32'hDEADBEEF;
    expect_rsp(5, 32'hDEADBEEF);
    tick();
    m_rsp_valid = 1'b0;
    drive(5, 1'b1, 1'b0, 32'h30);
    hwpe_evt = 1'b1;
    #1 chk("evt_rd_ready", {24'h0, req_ready}, 32'h20);
    tick();
    hwpe_evt = 1'b0;
    drive(5, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h40);
    #1 chk("evt_idle", {31'h0, busy}, 32'h0);
    tick();
    #1 chk("no_grant_pending", {31'h0, busy}, 32'h0);
    m_rsp_valid = 1'b1; m_rsp_data = 32'hCAFE0001;
    expect_rsp(5, 32'hCAFE0001);
    tick();
    m_rsp_valid = 1'b0;
    #1 chk("no_grant_pending2", {31'h0, busy}, 32'h0);
    tick();

    // Core 1 granted, then goes quiet: timeout after 16 owned cycles.
    drive(1, 1'b0, 1'b0, 32'h0);
    drive(3, 1'b1, 1'b0, 32'h50);
    m_ready = 1'b0;
    #1 chk("grant1_owner", {29'h0, owner}, 32'h1);
    seen = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) #1;
      if (timeout === 1'b1) begin
        seen = k;
        break;
      end
      tick();
    end
    chk("timeout_cycle", 32'(seen), 32'd15);
    tick();
    #1 chk("timeout_pulse_end", {31'h0, timeout}, 32'h0);
    tick();
    drive(3, 1'b0, 1'b0, 32'h0);
    #1 chk("grant3_owner", {29'h0, owner}, 32'h3);
    repeat (15) tick();
    drive(3, 1'b1, 1'b1, 32'h04);
    expect_rsp(3, 32'h0);
    #1;
    chk("release_beats_timeout", {31'h0, timeout}, 32'h0);
    chk("release3_ready", {24'h0, req_ready}, 32'h08);
    tick();
    drive(3, 1'b0, 1'b0, 32'h0);
    #1 chk("release3_idle", {31'h0, busy}, 32'h0);

    // Reset with a response outstanding; the late response is dropped.
    tick();
    drive(6, 1'b1, 1'b0, 32'h60);
    m_ready = 1'b1;
    tick();
    #1 chk("grant6_mvalid", {31'h0, m_valid}, 32'h1);
    tick();
    drive(6, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_rsp_valid = 1'b1; m_rsp_data = 32'h77;
    #1;
    chk("late_rsp_dropped", {24'h0, rsp_valid}, 32'h0);
    chk("rst2_busy", {31'h0, busy}, 32'h0);
    chk("rst2_ready", {24'h0, req_ready}, 32'h0);
    chk("rst2_mvalid", {31'h0, m_valid}, 32'h0);
    chk("rst2_owner", {29'h0, owner}, 32'h0);
    tick();
    m_rsp_valid = 1'b0;

    // Everyone releases immediately: round-robin 0..7 then wrap to 0.
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 32'h04);
    for (int i = 0; i <= NP; i++) begin
      found = 1'b0;
      for (int w = 0; w < 10; w++) begin
        #1;
        if (busy === 1'b1) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      chk("rr_granted", {31'h0, found}, 32'h1);
      chk("rr_owner", {29'h0, owner}, 32'(i % NP));
      chk("rr_ready", {24'h0, req_ready}, 32'(1 << (i % NP)));
      expect_rsp(i % NP, 32'h0);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
